// File: rtl/pool_ofm_writeback_if.sv
// Pixel-in stream and SRAM write port of the pooled output-feature-map writeback stage.
// master = writeback block side, slave = producer/SRAM environment side.
interface pool_ofm_writeback_if #(
    parameter int DATA_WID = 16,
    parameter int PACK_NUM = 4,
    parameter int ADDR_B   = 12
);
    logic                         in_valid;
    logic [DATA_WID-1:0]          in_data;
    logic                         in_last;
    logic                         in_ready;
    logic                         mem_wr_en;
    logic [ADDR_B-1:0]            mem_wr_addr;
    logic [PACK_NUM*DATA_WID-1:0] mem_wr_data;
    logic                         mem_wr_ready;

    modport master (
        input  in_valid, in_data, in_last, mem_wr_ready,
        output in_ready, mem_wr_en, mem_wr_addr, mem_wr_data
    );

    modport slave (
        output in_valid, in_data, in_last, mem_wr_ready,
        input  in_ready, mem_wr_en, mem_wr_addr, mem_wr_data
    );
endinterface

// File: rtl/pool_ofm_writeback.sv
// Packs pooled pixels PACK_NUM per word, queues words in a small FIFO and
// writes them into a ring region of output feature-map SRAM.
module pool_ofm_writeback #(
    parameter int DATA_WID   = 16,
    parameter int PACK_NUM   = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_B     = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_start,
    input  logic [ADDR_B-1:0]     cfg_base_addr,
    input  logic [ADDR_B-1:0]     cfg_num_words,
    pool_ofm_writeback_if.master  bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int LW = $clog2(PACK_NUM);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef logic [PACK_NUM-1:0][DATA_WID-1:0] word_t;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_B-1:0] base_q, base_d, nwords_q, nwords_d, wptr_q, wptr_d;
    logic [LW-1:0]     lane_cnt_q, lane_cnt_d;
    word_t             lane_q, lane_d;
    logic [PW-1:0]     fwr_q, fwr_d, frd_q, frd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              err_q, err_d;
    word_t             fifo_mem [FIFO_DEPTH];
    word_t             push_word;
    logic              accept, push, pop, wr_en;

    assign bus.in_ready = (state_q == RUN) && (cnt_q != CW'(FIFO_DEPTH));
    assign accept       = bus.in_valid && bus.in_ready;
    assign push         = accept && (bus.in_last || lane_cnt_q == LW'(PACK_NUM - 1));
    assign wr_en        = (state_q == RUN || state_q == FLUSH) && (cnt_q != '0);
    assign pop          = wr_en && bus.mem_wr_ready;

    assign bus.mem_wr_en   = wr_en;
    // Outputs are forced to zero when idle so reset leaves a clean bus.
    assign bus.mem_wr_addr = wr_en ? base_q + wptr_q : '0;
    assign bus.mem_wr_data = wr_en ? fifo_mem[frd_q] : '0;

    assign busy = (state_q == RUN) || (state_q == FLUSH);
    assign done = (state_q == DONE);
    assign err  = err_q;

    // Lanes below the counter come from registers, the current lane from the
    // input, and anything above is zero padding for a short final word.
    always_comb begin
        push_word = '0;
        for (int i = 0; i < PACK_NUM; i++) begin
            if (LW'(i) < lane_cnt_q)
                push_word[i] = lane_q[i];
            else if (LW'(i) == lane_cnt_q)
                push_word[i] = bus.in_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        nwords_d   = nwords_q;
        wptr_d     = wptr_q;
        lane_cnt_d = lane_cnt_q;
        lane_d     = lane_q;
        err_d      = err_q;
        unique case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    state_d    = RUN;
                    base_d     = cfg_base_addr;
                    nwords_d   = cfg_num_words;
                    err_d      = 1'b0;
                    lane_cnt_d = '0;
                    wptr_d     = '0;
                end else if (bus.in_valid) begin
                    err_d = 1'b1;
                end
            end
            RUN: begin
                if (accept) begin
                    lane_d[lane_cnt_q] = bus.in_data;
                    lane_cnt_d         = push ? '0 : lane_cnt_q + LW'(1);
                    if (bus.in_last) state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (bus.in_valid) err_d = 1'b1;
                if (cnt_q == '0) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (pop)
            wptr_d = (wptr_q == nwords_q - ADDR_B'(1)) ? '0 : wptr_q + ADDR_B'(1);
    end

    always_comb begin
        fwr_d = push ? fwr_q + PW'(1) : fwr_q;
        frd_d = pop  ? frd_q + PW'(1) : frd_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            nwords_q   <= '0;
            wptr_q     <= '0;
            lane_cnt_q <= '0;
            lane_q     <= '0;
            fwr_q      <= '0;
            frd_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            nwords_q   <= nwords_d;
            wptr_q     <= wptr_d;
            lane_cnt_q <= lane_cnt_d;
            lane_q     <= lane_d;
            fwr_q      <= fwr_d;
            frd_q      <= frd_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[fwr_q] <= push_word;
    end
endmodule

// File: tb/tb_pool_ofm_writeback.sv
// Scoreboard bench for pool_ofm_writeback: a packing/address model queues
// expected writes as pixels are accepted; the write monitor pops and compares.
module tb_pool_ofm_writeback;
    localparam int DW = 16;
    localparam int PN = 4;
    localparam int AB = 12;

    typedef struct {
        logic [AB-1:0]    a;
        logic [PN*DW-1:0] d;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_start = 1'b0;
    logic [AB-1:0] cfg_base = '0;
    logic [AB-1:0] cfg_num = '0;
    logic          busy, done, err;

    pool_ofm_writeback_if #(.DATA_WID(DW), .PACK_NUM(PN), .ADDR_B(AB)) bus();

    pool_ofm_writeback #(.DATA_WID(DW), .PACK_NUM(PN), .FIFO_DEPTH(8), .ADDR_B(AB)) dut (
        .clk(clk), .reset(rst_n), .cfg_start(cfg_start),
        .cfg_base_addr(cfg_base), .cfg_num_words(cfg_num),
        .bus(bus), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    wr_t           exp_q[$];
    int            n_tests = 0, n_fail = 0, wr_cnt = 0, done_cnt = 0;
    logic [AB-1:0] m_base, m_n, m_ptr;
    int            m_cnt = 0;
    logic [DW-1:0] m_lane [PN];
    logic          hold = 1'b0;
    logic [AB-1:0] h_a;
    logic [PN*DW-1:0] h_d;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void m_accept(input logic [DW-1:0] d, input logic last);
        wr_t w;
        m_lane[m_cnt] = d;
        m_cnt++;
        if (m_cnt == PN || last) begin
            w.d = '0;
            for (int i = 0; i < m_cnt; i++) w.d[i*DW +: DW] = m_lane[i];
            w.a = m_base + m_ptr;
            m_ptr = (m_ptr == m_n - AB'(1)) ? '0 : m_ptr + AB'(1);
            exp_q.push_back(w);
            m_cnt = 0;
        end
    endfunction

    always @(negedge clk) begin
        wr_t w;
        if (bus.mem_wr_en && bus.mem_wr_ready) begin
            wr_cnt++;
            if (exp_q.size() == 0) chk("unexp_wr", 1, 0);
            else begin
                w = exp_q.pop_front();
                chk("wr_addr", 64'(bus.mem_wr_addr), 64'(w.a));
                chk("wr_data", bus.mem_wr_data, w.d);
            end
        end
        if (hold) begin
            chk("hold_en", 64'(bus.mem_wr_en), 1);
            chk("hold_addr", 64'(bus.mem_wr_addr), 64'(h_a));
            chk("hold_data", bus.mem_wr_data, h_d);
        end
        hold = rst_n && bus.mem_wr_en && !bus.mem_wr_ready;
        h_a  = bus.mem_wr_addr;
        h_d  = bus.mem_wr_data;
        if (done) begin
            done_cnt++;
            chk("busy_at_done", 64'(busy), 0);
        end
    end

    // All tasks are entered and left 1 time unit after a rising edge.
    task automatic start(input logic [AB-1:0] base, input logic [AB-1:0] n);
        cfg_start = 1'b1; cfg_base = base; cfg_num = n;
        m_base = base; m_n = n; m_ptr = '0; m_cnt = 0;
        @(posedge clk); #1;
        cfg_start = 1'b0;
    endtask

    task automatic send_px(input logic [DW-1:0] d, input logic last);
        int t = 0;
        bus.in_valid = 1'b1; bus.in_data = d; bus.in_last = last;
        @(negedge clk);
        while (!bus.in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) chk("in_ready_timeout", 0, 1);
        else m_accept(d, last);
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
    endtask

    task automatic wait_done();
        int d0 = done_cnt;
        int t = 0;
        while (done_cnt == d0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        chk("done_seen", 64'(done_cnt != d0), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("done_once", done_cnt - d0, 1);
        chk("sb_drain", exp_q.size(), 0);
        chk("busy_after", 64'(busy), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 0);
        chk({tag, "_wr_en"}, 64'(bus.mem_wr_en), 0);
        chk({tag, "_addr"}, 64'(bus.mem_wr_addr), 0);
        chk({tag, "_data"}, bus.mem_wr_data, 0);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_done"}, 64'(done), 0);
        chk({tag, "_err"}, 64'(err), 0);
    endtask

    initial begin
        int w0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.mem_wr_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // basic pack, two full words
        bus.mem_wr_ready = 1'b1;
        w0 = wr_cnt;
        start(12'h100, 12'd16);
        @(negedge clk);
        chk("busy_run", 64'(busy), 1);
        @(posedge clk); #1;
        for (int i = 1; i <= 8; i++) send_px(DW'(i), i == 8);
        wait_done();
        chk("basic_writes", wr_cnt - w0, 2);

        // short final word is zero padded
        w0 = wr_cnt;
        start(12'h180, 12'd16);
        for (int i = 'hA; i <= 'hE; i++) send_px(DW'(i), i == 'hE);
        wait_done();
        chk("partial_writes", wr_cnt - w0, 2);

        // backpressure until the FIFO is full
        bus.mem_wr_ready = 1'b0;
        w0 = wr_cnt;
        start(12'h200, 12'd64);
        for (int i = 0; i < 32; i++) send_px(DW'(16'h100 + i), 1'b0);
        bus.in_valid = 1'b1; bus.in_data = 16'h120;
        repeat (6) @(negedge clk);
        chk("full_in_ready", 64'(bus.in_ready), 0);
        chk("full_no_wr", wr_cnt - w0, 0);
        chk("full_sb_depth", exp_q.size(), 8);
        @(posedge clk); #1;
        bus.mem_wr_ready = 1'b1;
        for (int i = 32; i < 40; i++) send_px(DW'(16'h100 + i), i == 39);
        wait_done();
        chk("bp_writes", wr_cnt - w0, 10);

        // ring wrap
        w0 = wr_cnt;
        start(12'h3F0, 12'd3);
        for (int i = 0; i < 20; i++) send_px(DW'(16'h500 + i), i == 19);
        wait_done();
        chk("wrap_writes", wr_cnt - w0, 5);

        // protocol errors: stray pixel in IDLE, ignored start in RUN
        w0 = wr_cnt;
        bus.in_valid = 1'b1; bus.in_data = 16'hDEAD;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("idle_err", 64'(err), 1);
        chk("idle_no_wr", wr_cnt - w0, 0);
        @(posedge clk); #1;
        start(12'h050, 12'd4);
        @(negedge clk);
        chk("start_clr_err", 64'(err), 0);
        @(posedge clk); #1;
        send_px(16'd1, 1'b0);
        send_px(16'd2, 1'b0);
        cfg_start = 1'b1; cfg_base = 12'h700; cfg_num = 12'd1;
        send_px(16'd3, 1'b0);
        cfg_start = 1'b0;
        for (int i = 4; i <= 6; i++) send_px(DW'(i), i == 6);
        wait_done();
        chk("run_start_err", 64'(err), 0);

        // reset with 3 words queued and 2 lanes filled
        bus.mem_wr_ready = 1'b0;
        start(12'h123, 12'd16);
        for (int i = 0; i < 14; i++) send_px(DW'(16'h900 + i), 1'b0);
        chk("pre_rst_q", exp_q.size(), 3);
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk_zero("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.mem_wr_ready = 1'b1;
        w0 = wr_cnt;
        repeat (10) @(posedge clk);
        #1;
        chk("rst_no_wr", wr_cnt - w0, 0);
        start(12'h123, 12'd16);
        for (int i = 1; i <= 4; i++) send_px(DW'(16'h70 + i), i == 4);
        wait_done();
        chk("post_rst_writes", wr_cnt - w0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pool_ofm_writeback.md
Name: pool_ofm_writeback

Overview:
- Output stage directly downstream of the pooling + ReLU stage in the CNN datapath.
- Accepts the stream of rectified, pooled output pixels and packs PACK_NUM pixels into one memory word.
- Buffers packed words in a small FIFO and writes them to output feature-map SRAM through a valid/ready write port.
- Output addresses wrap inside a ring region set by configuration.

Parameters:
- DATA_WID, 16: width of one pooled pixel.
- PACK_NUM, 4: pixels per memory word; power of two, at least 2.
- FIFO_DEPTH, 8: number of packed-word entries; power of two.
- ADDR_B, 12: width of the SRAM word address.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- cfg_start  in  1  one-cycle pulse that starts a layer; honoured only in IDLE.
- cfg_base_addr  in  ADDR_B  first word address of the ring; sampled on start.
- cfg_num_words  in  ADDR_B  ring size in words, at least 1; sampled on start.
- in_valid  in  1  pooled pixel valid.
- in_data  in  DATA_WID  pooled pixel value.
- in_last  in  1  marks the final pixel of the layer; qualified by in_valid.
- in_ready  out  1  block can accept a pixel.
- mem_wr_en  out  1  write request valid.
- mem_wr_addr  out  ADDR_B  write word address.
- mem_wr_data  out  PACK_NUM*DATA_WID  packed word; lane 0 sits at the LSBs.
- mem_wr_ready  in  1  SRAM accepts the write this cycle.
- busy  out  1  high in RUN or FLUSH.
- done  out  1  one-cycle pulse when the layer is complete.
- err  out  1  sticky protocol error flag.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous, active-low.
- Reset values, applied when reset is low at a clk edge:
  - state = IDLE; FIFO empty; lane counter = 0; write pointer = 0.
  - in_ready, mem_wr_en, busy, done and err are all 0.
  - mem_wr_addr = 0, mem_wr_data = 0.
- Reset mid-operation: any partial word and all FIFO contents are discarded; no further write is issued.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Write transfer occurs when mem_wr_en && mem_wr_ready.
  - mem_wr_addr and mem_wr_data must hold stable while mem_wr_en is high and mem_wr_ready is low.
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - On cfg_start: latch base and size, clear err, lane counter = 0, write pointer = 0, go to RUN.
  - in_valid high in IDLE sets err; the pixel is dropped.
- RUN:
  - in_ready = (FIFO count < FIFO_DEPTH). The count is the registered value; a pop in the same cycle does not raise in_ready.
  - Each accepted pixel is stored in lane[lane counter], and the lane counter increments.
  - On the PACK_NUM-th pixel, the assembled word is pushed the same cycle and the lane counter returns to 0.
  - Accepted in_last pushes the word immediately; unfilled upper lanes are zero-padded. Then go to FLUSH.
  - in_last on a pixel that fills lane PACK_NUM-1 produces exactly one push, with no extra padding word.
- FLUSH:
  - in_ready = 0.
  - in_valid high during FLUSH sets err; the pixel is dropped.
  - When the FIFO is empty and no write is outstanding, go to DONE.
- DONE: done = 1 for one cycle, then IDLE.
- cfg_start in any state other than IDLE is ignored.
- Write side (RUN and FLUSH):
  - mem_wr_en = FIFO not empty.
  - mem_wr_data = FIFO head.
  - mem_wr_addr = base + write pointer.
- Latency: a word pushed at edge N is presented on mem_wr_en after edge N (registered FIFO). No same-cycle bypass.
- Address wrap:
  - On each write transfer the write pointer increments.
  - When the pointer reaches cfg_num_words - 1, the next transfer sets it to 0.
  - Addition is modulo 2^ADDR_B.
- Simultaneous push and pop: allowed at any count below full, and the count is unchanged.
  - Full: no push is possible, because in_ready is 0; a pop is allowed.
  - Empty: a push only; mem_wr_en rises the next cycle.
- busy = (state == RUN || state == FLUSH).

Test Plan:
- Basic pack: PACK_NUM=4, base=0x100, size=16; send pixels 1..8 back-to-back, last on 8, mem_wr_ready=1 -> two writes:
  - addr 0x100, data {4,3,2,1};
  - addr 0x101, data {8,7,6,5};
  - done pulses once; busy falls together with the done cycle.
- Partial flush: send 5 pixels 0xA..0xE, last on 0xE -> second write data {0,0,0,0xE}; exactly 2 writes.
- Backpressure/full: hold mem_wr_ready=0 and stream 40 pixels -> in_ready drops after 32 accepted (8 words); no data lost. Release ready -> words appear in order and addresses increment by 1.
- Wrap: base=0x3F0, size=3, send 5 words -> addresses 0x3F0, 0x3F1, 0x3F2, 0x3F0, 0x3F1.
- Protocol errors:
  - in_valid in IDLE -> err=1 with no write.
  - cfg_start during RUN -> ignored; err stays set until the next accepted start, which clears it.
- Reset mid-run: assert reset low with 3 words queued and a partial lane filled -> next cycle all outputs are 0 and no writes appear. A new start then writes from base with pointer 0.
